// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory (1-cycle read latency)
// between the CPU fetch port (IF) and data port (MM). At most one grant per
// cycle; read data is routed back to its owner the cycle after the grant.
// Build option: define RISCV_ARB_RR_EN for round-robin conflict resolution
// (no starvation counter). Default is fixed MM priority with a starvation
// counter that forces an IF grant after MAX_WAIT consecutive denials.
module riscv_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_mm_req,
  input  logic [XLEN-1:0] i_mm_addr,
  input  logic            i_mm_wen,
  input  logic [3:0]      i_mm_strb,
  input  logic [XLEN-1:0] i_mm_wdata,
  output logic            o_mm_gnt,
  output logic            o_mm_rvalid,
  output logic [XLEN-1:0] o_mm_rdata,
  output logic            o_mem_en,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wen,
  output logic [3:0]      o_mem_strb,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_if_starve
);

  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_MM} rsp_e;

  rsp_e rsp_owner_q, rsp_owner_d;
  logic if_gnt, mm_gnt;

`ifdef RISCV_ARB_RR_EN
  // rr_last_mm_q: 1 when the most recent grant went to MM, 0 when to IF
  logic rr_last_mm_q, rr_last_mm_d;

  // Round-robin grant: on conflict, favour whoever was not granted last
  always_comb begin
    if_gnt = 1'b0;
    mm_gnt = 1'b0;
    if (i_rstn) begin
      if (i_if_req && i_mm_req) begin
        if (rr_last_mm_q) if_gnt = 1'b1;
        else              mm_gnt = 1'b1;
      end else begin
        if_gnt = i_if_req;
        mm_gnt = i_mm_req;
      end
    end
  end

  // Remember the last winner; idle cycles leave it unchanged
  always_comb begin
    rr_last_mm_d = rr_last_mm_q;
    if (mm_gnt)      rr_last_mm_d = 1'b1;
    else if (if_gnt) rr_last_mm_d = 1'b0;
  end

  // Last-winner register; reset as if IF had won so MM takes the first conflict
  always_ff @(posedge i_clk) begin
    if (!i_rstn) rr_last_mm_q <= 1'b0;
    else         rr_last_mm_q <= rr_last_mm_d;
  end

  assign o_if_starve = 1'b0;
`else
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              if_due;

  // IF has been denied long enough that it must win this cycle
  assign if_due = i_if_req && (wait_cnt_q == MAX_CNT);

  // Fixed priority: MM wins unless IF is due
  always_comb begin
    if_gnt = 1'b0;
    mm_gnt = 1'b0;
    if (i_rstn) begin
      if (if_due)        if_gnt = 1'b1;
      else if (i_mm_req) mm_gnt = 1'b1;
      else if (i_if_req) if_gnt = 1'b1;
    end
  end

  // Count consecutive IF denials, saturating; any IF grant or idle IF clears it
  always_comb begin
    wait_cnt_d = '0;
    if (i_if_req && !if_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  // Starvation counter register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end

  assign o_if_starve = if_gnt && (wait_cnt_q == MAX_CNT);
`endif

  assign o_if_gnt = if_gnt;
  assign o_mm_gnt = mm_gnt;

  // Steer the granted requester onto the memory port; IF is always a read
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_strb  = '0;
    o_mem_wdata = '0;
    if (if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
    end else if (mm_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_mm_addr;
      o_mem_wen   = i_mm_wen;
      o_mem_strb  = i_mm_strb;
      o_mem_wdata = i_mm_wdata;
    end
  end

  // Track who owns next cycle's read data; writes produce no response
  always_comb begin
    rsp_owner_d = RSP_NONE;
    if (if_gnt)                  rsp_owner_d = RSP_IF;
    else if (mm_gnt && !i_mm_wen) rsp_owner_d = RSP_MM;
  end

  // Response owner register; reset drops any in-flight response
  always_ff @(posedge i_clk) begin
    if (!i_rstn) rsp_owner_q <= RSP_NONE;
    else         rsp_owner_q <= rsp_owner_d;
  end

  // Gate by reset so an in-flight response vanishes in the reset cycle itself
  assign o_if_rvalid = i_rstn && (rsp_owner_q == RSP_IF);
  assign o_mm_rvalid = i_rstn && (rsp_owner_q == RSP_MM);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_mm_rdata  = o_mm_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: random and directed request streams,
// a grant/ownership reference model and a read-response scoreboard.
module tb_riscv_mem_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_if_req = 1'b0;
  logic [XLEN-1:0] i_if_addr = '0;
  logic            o_if_gnt, o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;
  logic            i_mm_req = 1'b0;
  logic [XLEN-1:0] i_mm_addr = '0;
  logic            i_mm_wen = 1'b0;
  logic [3:0]      i_mm_strb = '0;
  logic [XLEN-1:0] i_mm_wdata = '0;
  logic            o_mm_gnt, o_mm_rvalid;
  logic [XLEN-1:0] o_mm_rdata;
  logic            o_mem_en, o_mem_wen;
  logic [XLEN-1:0] o_mem_addr, o_mem_wdata;
  logic [3:0]      o_mem_strb;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_if_starve;

  always #5 i_clk = ~i_clk;

  riscv_mem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_mm_req(i_mm_req), .i_mm_addr(i_mm_addr), .i_mm_wen(i_mm_wen),
    .i_mm_strb(i_mm_strb), .i_mm_wdata(i_mm_wdata), .o_mm_gnt(o_mm_gnt),
    .o_mm_rvalid(o_mm_rvalid), .o_mm_rdata(o_mm_rdata),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_strb(o_mem_strb), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_if_starve(o_if_starve));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstarve = 0;

  typedef struct { int cyc; logic [31:0] d; } rsp_t;
  rsp_t qif[$];
  rsp_t qmm[$];

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 32'h0050_0093;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory macro stand-in, driven only by the DUT's memory port
  logic [31:0] phys [256];
  logic [31:0] rd_q;
  assign i_mem_rdata = rd_q;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
    end else if (o_mem_en && o_mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_strb[b]) phys[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    rd_q <= (o_mem_en && !o_mem_wen) ? phys[o_mem_addr[9:2]] : $urandom;
  end

  // Reference memory and requester/model state (bench-only)
  logic [31:0] ref_m [256];
  logic        if_pend = 1'b0, mm_pend = 1'b0, mmwen = 1'b0;
  logic [31:0] ifa = '0, mma = '0, mmw = '0;
  logic [3:0]  mms = '0;
  int          denied = 0;
  bit          last_mm = 1'b0;

  // One bus cycle: issue requests, predict arbitration, check, record responses
  task automatic step(input int p_if, input int p_mm, input logic rst);
    logic eif, emm, estv;
    logic [31:0] idx;
    i_rstn = rst;
    if (!if_pend && $urandom_range(0, 99) < p_if) begin
      if_pend = 1'b1; ifa = 32'($urandom_range(0, 255)) << 2;
    end
    if (!mm_pend && $urandom_range(0, 99) < p_mm) begin
      mm_pend = 1'b1; mma = 32'($urandom_range(0, 255)) << 2;
      mmwen = ($urandom_range(0, 2) == 0); mms = 4'($urandom_range(1, 15)); mmw = $urandom;
    end
    i_if_req   = if_pend;
    i_if_addr  = if_pend ? ifa : $urandom;
    i_mm_req   = mm_pend;
    i_mm_addr  = mm_pend ? mma : $urandom;
    i_mm_wen   = mm_pend ? mmwen : 1'($urandom);
    i_mm_strb  = mm_pend ? mms : 4'($urandom);
    i_mm_wdata = mm_pend ? mmw : $urandom;
    @(negedge i_clk);
    eif = 1'b0; emm = 1'b0; estv = 1'b0;
    if (rst) begin
`ifdef RISCV_ARB_RR_EN
      if (if_pend && mm_pend) begin eif = last_mm; emm = !last_mm; end
      else begin eif = if_pend; emm = mm_pend; end
`else
      eif  = if_pend && (!mm_pend || denied == MAX_WAIT);
      emm  = mm_pend && !eif;
      estv = eif && (denied == MAX_WAIT);
`endif
    end
    if (estv) nstarve++;
    chk("if_gnt", o_if_gnt, eif);
    chk("mm_gnt", o_mm_gnt, emm);
    chk("if_starve", o_if_starve, estv);
    chk("mem_en", o_mem_en, eif | emm);
    chk("mem_addr", o_mem_addr, eif ? ifa : (emm ? mma : 32'h0));
    chk("mem_wen", o_mem_wen, emm & mmwen);
    chk("mem_strb", o_mem_strb, emm ? mms : 4'h0);
    chk("mem_wdata", o_mem_wdata, emm ? mmw : 32'h0);
    if (eif) begin
      idx = ifa >> 2;
      qif.push_back('{cyc: cyc + 1, d: ref_m[idx[7:0]]});
    end
    if (emm) begin
      idx = mma >> 2;
      if (!mmwen) qmm.push_back('{cyc: cyc + 1, d: ref_m[idx[7:0]]});
      else
        for (int b = 0; b < 4; b++)
          if (mms[b]) ref_m[idx[7:0]][8*b +: 8] = mmw[8*b +: 8];
    end
    if (!rst) begin
      denied = 0; last_mm = 1'b0;
    end else begin
      denied = (if_pend && !eif) ? ((denied < MAX_WAIT) ? denied + 1 : MAX_WAIT) : 0;
      if (eif) last_mm = 1'b0;
      if (emm) last_mm = 1'b1;
    end
    if (eif) if_pend = 1'b0;
    if (emm) mm_pend = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (if_pend || mm_pend); i++) step(0, 0, 1'b1);
    chk("drain_done", {30'b0, if_pend, mm_pend}, 32'h0);
    step(0, 0, 1'b1);
  endtask

  // Response monitor: compares each cycle's rvalid/rdata with the scoreboard
  always @(negedge i_clk) begin
    rsp_t rs;
    logic ev;
    logic [31:0] ed;
    ev = 1'b0; ed = '0;
    if (qif.size() > 0 && qif[0].cyc == cyc) begin
      rs = qif.pop_front();
      if (i_rstn) begin ev = 1'b1; ed = rs.d; end
    end
    chk("if_rvalid", o_if_rvalid, ev);
    chk("if_rdata", o_if_rdata, ed);
    ev = 1'b0; ed = '0;
    if (qmm.size() > 0 && qmm[0].cyc == cyc) begin
      rs = qmm.pop_front();
      if (i_rstn) begin ev = 1'b1; ed = rs.d; end
    end
    chk("mm_rvalid", o_mm_rvalid, ev);
    chk("mm_rdata", o_mm_rdata, ed);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_m[i] = init_val(i);
    @(posedge i_clk); #1;
    // Reset held with both requests pending, then MM must win first
    if_pend = 1'b1; ifa = 32'h40;
    mm_pend = 1'b1; mma = 32'h80; mmwen = 1'b0; mms = 4'h0; mmw = '0;
    repeat (3) step(0, 0, 1'b0);
    drain();
    // Lone fetch
    if_pend = 1'b1; ifa = 32'h10;
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);
    // Conflict on a read of 0x200
    if_pend = 1'b1; ifa = 32'h200;
    mm_pend = 1'b1; mma = 32'h200; mmwen = 1'b0;
    drain();
    // Back-to-back data traffic with a held fetch
    if_pend = 1'b1; ifa = 32'h20;
    repeat (12) step(0, 100, 1'b1);
    drain();
`ifndef RISCV_ARB_RR_EN
    chk("starve_seen", 32'(nstarve > 0), 32'h1);
`endif
    // Partial write then read-back
    mm_pend = 1'b1; mma = 32'h300; mmwen = 1'b1; mms = 4'b0011; mmw = 32'hDEAD_BEEF;
    step(0, 0, 1'b1);
    mm_pend = 1'b1; mma = 32'h300; mmwen = 1'b0;
    step(0, 0, 1'b1);
    step(0, 0, 1'b1);
    // Reset right after a fetch grant drops its response
    if_pend = 1'b1; ifa = 32'h10;
    step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    step(0, 0, 1'b1);
    // Continuous conflicts after reset
    repeat (8) step(100, 100, 1'b1);
    drain();
    // Random traffic with occasional resets
    repeat (3000) step(50, 60, $urandom_range(0, 199) != 0);
    drain();
    step(0, 0, 1'b1);
    chk("rsp_drained", 32'(qif.size() + qmm.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
